// File: rtl/conv_window_scheduler.sv
// Convolution window scheduler: walks every kernel-sized window origin of an
// IMG_H x IMG_W image in row-major order, issues one window per cycle to a
// pipelined PE under a credit limit, and streams PE results out through a
// small FIFO with a running output index.
module conv_window_scheduler #(
  parameter int WIDTH       = 8,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int kernel_size = 5,
  parameter int PE_LATENCY  = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     pe_in_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  input  logic [WIDTH-1:0]         pe_result,
  input  logic                     pe_result_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2((IMG_H-kernel_size+1)*(IMG_W-kernel_size+1))-1:0] out_idx,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int OH   = IMG_H - kernel_size + 1;
  localparam int OW   = IMG_W - kernel_size + 1;
  localparam int RW   = $clog2(IMG_H);
  localparam int CLW  = $clog2(IMG_W);
  localparam int IW   = $clog2(OH * OW);
  localparam int AW   = $clog2(FIFO_DEPTH);
  // Counters get headroom beyond FIFO_DEPTH so a misbehaving PE cannot wrap them.
  localparam int CW   = $clog2(FIFO_DEPTH + PE_LATENCY + 1);

  localparam logic [RW-1:0]  LAST_ROW = RW'(OH - 1);
  localparam logic [CLW-1:0] LAST_COL = CLW'(OW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     count;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [WIDTH-1:0]  mem [FIFO_DEPTH];

  logic pop;
  logic full;
  logic push;
  logic credit;

  assign pop       = out_valid && out_ready;
  assign full      = (count == CW'(FIFO_DEPTH));
  // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign push      = pe_result_valid && (!full || pop);
  assign credit    = ((CW+1)'(inflight) + (CW+1)'(count)) < (CW+1)'(FIFO_DEPTH);
  assign pe_in_valid = (state == RUN) && credit;
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  // Pass sequencing: window origin walk, drain wait and output index.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= IDLE;
      win_row <= '0;
      win_col <= '0;
      out_idx <= '0;
    end else begin
      if (state == IDLE && start) begin
        out_idx <= '0;
      end else if (pop) begin
        out_idx <= out_idx + IW'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            win_row <= '0;
            win_col <= '0;
          end
        end
        RUN: begin
          if (pe_in_valid) begin
            if (win_col == LAST_COL) begin
              win_col <= '0;
              if (win_row == LAST_ROW) begin
                win_row <= '0;
                state   <= DRAIN;
              end else begin
                win_row <= win_row + RW'(1);
              end
            end else begin
              win_col <= win_col + CLW'(1);
            end
          end
        end
        DRAIN: begin
          if (inflight == '0 && count == '0) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Credit bookkeeping, FIFO pointers and the sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err      <= 1'b0;
    end else begin
      if (pe_in_valid && !pe_result_valid) begin
        inflight <= inflight + CW'(1);
      end else if (!pe_in_valid && pe_result_valid && inflight != '0) begin
        inflight <= inflight - CW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (pe_result_valid && (inflight == '0 || (full && !pop))) err <= 1'b1;
    end
  end

  // Result storage; no reset needed since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pe_result;
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: a PE pipeline model produces random results,
// a negedge monitor logs issues/outputs and tracks credit occupancy from the
// observed handshakes, and each test task compares the logs to the expected
// row-major window walk and in-order result stream.
module tb_conv_window_scheduler;

  localparam int WIDTH = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int K     = 5;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int OH    = IMG_H - K + 1;
  localparam int OW    = IMG_W - K + 1;
  localparam int NWIN  = OH * OW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, err, pe_in_valid;
  logic [2:0]       win_row, win_col;
  logic [WIDTH-1:0] pe_result;
  logic             pe_result_valid;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_idx;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             force_rv = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  conv_window_scheduler #(
    .WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .kernel_size(K),
    .PE_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .pe_in_valid(pe_in_valid), .win_row(win_row), .win_col(win_col),
    .pe_result(pe_result), .pe_result_valid(pe_result_valid),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // PE model: result_valid is high LAT cycles after in_valid, counting the issue cycle.
  logic [LAT-2:0]   vpipe;
  logic [WIDTH-1:0] dpipe [LAT-1];
  logic [WIDTH-1:0] next_data;

  always @(posedge clk) begin
    if (rst_n) begin
      vpipe <= '0;
    end else begin
      for (int i = LAT - 2; i > 0; i--) begin
        vpipe[i] <= vpipe[i-1];
        dpipe[i] <= dpipe[i-1];
      end
      vpipe[0] <= pe_in_valid;
      dpipe[0] <= next_data;
    end
  end

  assign pe_result_valid = vpipe[LAT-2] | force_rv;
  assign pe_result       = dpipe[LAT-2];

  // Monitor logs
  int               iss_row[$];
  int               iss_col[$];
  logic [WIDTH-1:0] exp_data[$];
  int               got_idx[$];
  logic [WIDTH-1:0] got_data[$];
  int done_cnt = 0, credit_viol = 0, run_len = 0, max_run = 0;
  int tb_inflight = 0, tb_count = 0;

  always @(negedge clk) begin
    next_data = WIDTH'($urandom);
    if (rst_n) begin
      tb_inflight = 0;
      tb_count    = 0;
      run_len     = 0;
    end else begin
      if (pe_in_valid) begin
        if (tb_inflight + tb_count >= DEPTH) credit_viol++;
        iss_row.push_back(int'(win_row));
        iss_col.push_back(int'(win_col));
        exp_data.push_back(next_data);
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (out_valid && out_ready) begin
        got_idx.push_back(int'(out_idx));
        got_data.push_back(out_data);
      end
      if (done) done_cnt++;
      tb_inflight = tb_inflight + int'(pe_in_valid) - int'(pe_result_valid);
      tb_count    = tb_count + int'(pe_result_valid) - int'(out_valid && out_ready);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_row.delete(); iss_col.delete(); exp_data.delete();
    got_idx.delete(); got_data.delete();
    done_cnt = 0; credit_viol = 0; max_run = 0;
  endtask

  // mode 0: out_ready=1, 1: random, 2: toggling. poke: random start pulses while busy.
  task automatic drive_pass(input int mode, input bit poke, output bit timeout);
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    timeout = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) out_ready = ~out_ready;
      else out_ready = 1'b1;
      start = (poke && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      if (done) begin
        timeout = 1'b0;
        start = 1'b0;
        step();
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (2) step();
    rst_n = 1'b0;
    vectors++;
    if ({busy, done, err, pe_in_valid, out_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 00000", {busy, done, err, pe_in_valid, out_valid});
    end
    vectors++;
    if (win_row !== 3'd0 || win_col !== 3'd0 || out_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_idx: got row %0d col %0d idx %0d expected 0 0 0", win_row, win_col, out_idx);
    end
    step();
  endtask

  task automatic test_basic();
    bit to;
    clear_logs();
    drive_pass(0, 1'b0, to);
    repeat (3) step();
    vectors++;
    if (to) begin miscompares++; $display("FAIL basic_timeout: got no done expected done"); end
    vectors++;
    if (iss_row.size() != NWIN) begin
      miscompares++; $display("FAIL basic_issues: got %0d expected %0d", iss_row.size(), NWIN);
    end
    for (int i = 0; i < iss_row.size() && i < NWIN; i++) begin
      vectors++;
      if (iss_row[i] != i / OW || iss_col[i] != i % OW) begin
        miscompares++;
        $display("FAIL basic_window[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, iss_row[i], iss_col[i], i / OW, i % OW);
      end
    end
    vectors++;
    if (max_run != NWIN) begin
      miscompares++; $display("FAIL basic_consecutive: got run %0d expected %0d", max_run, NWIN);
    end
    vectors++;
    if (got_idx.size() != NWIN) begin
      miscompares++; $display("FAIL basic_outputs: got %0d expected %0d", got_idx.size(), NWIN);
    end
    for (int i = 0; i < got_idx.size() && i < exp_data.size(); i++) begin
      vectors++;
      if (got_idx[i] != i || got_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL basic_out[%0d]: got idx %0d data %0h expected idx %0d data %0h", i, got_idx[i], got_data[i], i, exp_data[i]);
      end
    end
    vectors++;
    if (done_cnt != 1 || err !== 1'b0 || credit_viol != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_status: got done %0d err %b viol %0d busy %b expected 1 0 0 0", done_cnt, err, credit_viol, busy);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_logs();
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    vectors++;
    if (iss_row.size() != DEPTH || pe_in_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_stall: got issues %0d pe_in_valid %b expected %0d 0", iss_row.size(), pe_in_valid, DEPTH);
    end
    vectors++;
    if (out_valid !== 1'b1 || out_idx !== 4'd0 || tb_count != DEPTH || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_hold: got valid %b idx %0d held %0d busy %b expected 1 0 %0d 1", out_valid, out_idx, tb_count, busy, DEPTH);
    end
    vectors++;
    if (exp_data.size() == 0 || out_data !== exp_data[0]) begin
      miscompares++; $display("FAIL bp_head_data: got %0h expected first result", out_data);
    end
    out_ready = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (done) begin to = 1'b0; step(); break; end
    end
    vectors++;
    if (to || iss_row.size() != NWIN || got_idx.size() != NWIN || done_cnt != 1) begin
      miscompares++;
      $display("FAIL bp_resume: got timeout %b issues %0d outs %0d done %0d expected 0 %0d %0d 1", to, iss_row.size(), got_idx.size(), done_cnt, NWIN, NWIN);
    end
    for (int i = 0; i < got_idx.size() && i < exp_data.size(); i++) begin
      vectors++;
      if (got_idx[i] != i || got_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL bp_out[%0d]: got idx %0d data %0h expected idx %0d data %0h", i, got_idx[i], got_data[i], i, exp_data[i]);
      end
    end
    vectors++;
    if (credit_viol != 0 || err !== 1'b0) begin
      miscompares++; $display("FAIL bp_credit: got viol %0d err %b expected 0 0", credit_viol, err);
    end
  endtask

  task automatic test_restart_ignored();
    bit to;
    clear_logs();
    drive_pass(0, 1'b1, to);
    repeat (5) step();
    vectors++;
    if (to || iss_row.size() != NWIN || done_cnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_ignored: got timeout %b issues %0d done %0d busy %b expected 0 %0d 1 0", to, iss_row.size(), done_cnt, busy, NWIN);
    end
    vectors++;
    if (got_idx.size() != NWIN || got_idx[NWIN-1] != NWIN - 1) begin
      miscompares++; $display("FAIL restart_outputs: got %0d outputs expected %0d", got_idx.size(), NWIN);
    end
  endtask

  task automatic test_reset_midpass();
    bit to;
    clear_logs();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (iss_row.size() >= 7) begin to = 1'b0; break; end
      step();
    end
    vectors++;
    if (to) begin miscompares++; $display("FAIL midrst_wait: got %0d issues expected 7", iss_row.size()); end
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    vectors++;
    if ({busy, done, err, pe_in_valid, out_valid} !== 5'b0 || win_row !== 3'd0 || win_col !== 3'd0 || out_idx !== 4'd0) begin
      miscompares++;
      $display("FAIL midrst_state: got flags %b row %0d col %0d idx %0d expected 00000 0 0 0", {busy, done, err, pe_in_valid, out_valid}, win_row, win_col, out_idx);
    end
    step();
    clear_logs();
    drive_pass(0, 1'b0, to);
    vectors++;
    if (to || iss_row.size() != NWIN || iss_row[0] != 0 || iss_col[0] != 0) begin
      miscompares++; $display("FAIL midrst_restart: got timeout %b issues %0d expected 0 %0d from (0,0)", to, iss_row.size(), NWIN);
    end
    vectors++;
    if (got_idx.size() != NWIN || got_idx[0] != 0 || got_data[0] !== exp_data[0]) begin
      miscompares++; $display("FAIL midrst_first_out: got %0d outputs expected %0d starting at idx 0", got_idx.size(), NWIN);
    end
  endtask

  task automatic test_err();
    clear_logs();
    out_ready = 1'b0;
    step();
    force_rv = 1'b1;
    step();
    force_rv = 1'b0;
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b expected 1", err); end
    repeat (5) step();
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b expected 1", err); end
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    vectors++;
    if (err !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL err_clear: got err %b valid %b expected 0 0", err, out_valid);
    end
    step();
  endtask

  task automatic test_stream(input int mode, input string tag);
    bit to;
    clear_logs();
    drive_pass(mode, 1'b0, to);
    vectors++;
    if (to || iss_row.size() != NWIN || got_idx.size() != NWIN || done_cnt != 1) begin
      miscompares++;
      $display("FAIL %s_pass: got timeout %b issues %0d outs %0d done %0d expected 0 %0d %0d 1", tag, to, iss_row.size(), got_idx.size(), done_cnt, NWIN, NWIN);
    end
    for (int i = 0; i < got_idx.size() && i < exp_data.size(); i++) begin
      vectors++;
      if (got_idx[i] != i || got_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL %s_out[%0d]: got idx %0d data %0h expected idx %0d data %0h", tag, i, got_idx[i], got_data[i], i, exp_data[i]);
      end
    end
    vectors++;
    if (credit_viol != 0 || err !== 1'b0) begin
      miscompares++; $display("FAIL %s_credit: got viol %0d err %b expected 0 0", tag, credit_viol, err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_restart_ignored();
    test_reset_midpass();
    test_err();
    test_stream(2, "toggle");
    for (int p = 0; p < 3; p++) test_stream(1, "random");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_window_scheduler.md
CONV_WINDOW_SCHEDULER -- requirements
Module: conv_window_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of PE operands and result.
REQ-002 SHALL have parameter IMG_W, default 8, input image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 8, input image height in pixels.
REQ-004 SHALL have parameter kernel_size, default 5, square kernel edge; stride fixed at 1.
REQ-005 SHALL have parameter PE_LATENCY, default 3, cycles from PE in_valid to result_valid.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, output result FIFO depth (power of 2).
REQ-007 SHALL use one clock; reset is synchronous and active-high.
REQ-008 clk  input  1  rising-edge clock for all state.
REQ-009 rst_n  input  1  synchronous reset, active-high (1 = reset), sampled on clk.
REQ-010 start  input  1  pulse; begins one full-image pass when idle.
REQ-011 busy  output  1  high while a pass is in progress.
REQ-012 done  output  1  one-cycle pulse at pass completion.
REQ-013 err  output  1  sticky protocol error flag.
REQ-014 pe_in_valid  output  1  drives PE in_valid; one window issued per high cycle.
REQ-015 win_row / win_col  output  clog2(IMG_H) / clog2(IMG_W)  top-left origin of issued window, to window buffer.
REQ-016 pe_result  input  WIDTH  PE result; pe_result_valid  input  1  PE result_valid.
REQ-017 out_data  output  WIDTH; out_idx  output  clog2(OH*OW); out_valid  output  1; out_ready  input  1  output stream, valid/ready.

Function
REQ-018 SHALL compute OH=IMG_H-kernel_size+1, OW=IMG_W-kernel_size+1; pass issues exactly OH*OW windows.
REQ-019 SHALL implement states IDLE, RUN, DRAIN, DONE; start in IDLE -> RUN next cycle; start in other states ignored.
REQ-020 RUN: issue (pe_in_valid=1) in a cycle only when inflight+fifo_count < FIFO_DEPTH (credit rule); otherwise pe_in_valid=0, origin held.
REQ-021 Window order row-major: col increments per issue, wraps OW-1 -> 0 with row+1; after issuing (OH-1,OW-1) -> DRAIN.
REQ-022 inflight counter: +1 on issue, -1 on pe_result_valid, unchanged on both simultaneously.
REQ-023 pe_result_valid SHALL push pe_result into FIFO same cycle; push and pop in same cycle allowed, including when full.
REQ-024 out_valid = FIFO non-empty; pop on out_valid&&out_ready; out_data/out_idx stable while out_valid&&!out_ready.
REQ-025 out_idx SHALL count 0..OH*OW-1 in pop order, reset to 0 at each start.
REQ-026 DRAIN -> DONE when inflight==0 and FIFO empty; DONE asserts done one cycle, -> IDLE.
REQ-027 busy=1 in RUN and DRAIN, 0 in IDLE and DONE.
REQ-028 err SHALL set on pe_result_valid with inflight==0, or push into full FIFO without pop; cleared only by reset.
REQ-029 Minimum pass length with out_ready=1: 1 (start) + OH*OW issue cycles + PE_LATENCY + 1 drain + 1 DONE.

Reset
REQ-030 On rst_n=1: state IDLE, busy=0, done=0, err=0, pe_in_valid=0, win_row=win_col=0, inflight=0, FIFO empty, out_valid=0, out_idx=0.
REQ-031 Reset mid-pass SHALL abort; PE shares rst_n so its pipeline is flushed; next start restarts at (0,0).

Verification
REQ-032 Defaults, out_ready=1, start pulse -> pe_in_valid high 16 consecutive cycles, windows (0,0),(0,1)..(3,3); 16 outputs out_idx 0..15 in order; single done pulse; err=0.
REQ-033 out_ready=0 from start -> exactly 4 issues then pe_in_valid=0, 4 entries held, out_idx=0 stable; out_ready=1 -> issuing resumes, all 16 delivered.
REQ-034 start pulsed again during RUN and DRAIN -> ignored; still exactly 16 issues and one done.
REQ-035 rst_n=1 one cycle after 7th issue -> all outputs at reset values next cycle; new start -> first window (0,0), out_idx 0.
REQ-036 pe_result_valid forced high while IDLE (inflight=0) -> err=1 next cycle, stays 1 until reset.
REQ-037 out_ready toggling 1/0 each cycle -> no issue when inflight+fifo_count=4, no lost or duplicated out_idx, err=0.
